// File: rtl/seqscan_ctrl_pkg.sv
// seqscan_ctrl shared definitions:
// FSM state encoding and default widths.
package seqscan_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PAT_W  = 4;
  localparam int DEF_CNT_W  = 8;
  localparam int NBYTES_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/seqscan_ctrl_if.sv
// seqscan_ctrl control/data bundle.
// master drives commands and bytes, slave is the scanner.
interface seqscan_ctrl_if
  import seqscan_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic                start;
  logic                abort;
  logic [PAT_W-1:0]    cfg_pattern;
  logic [NBYTES_W-1:0] cfg_nbytes;
  logic                din_valid;
  logic [DATA_W-1:0]   din_data;
  logic                din_ready;
  logic                busy;
  logic                done;
  logic                match_pulse;
  logic [CNT_W-1:0]    match_cnt;
  logic                overflow;

  modport master (
    output start,
    output abort,
    output cfg_pattern,
    output cfg_nbytes,
    output din_valid,
    output din_data,
    input  din_ready,
    input  busy,
    input  done,
    input  match_pulse,
    input  match_cnt,
    input  overflow
  );

  modport slave (
    input  start,
    input  abort,
    input  cfg_pattern,
    input  cfg_nbytes,
    input  din_valid,
    input  din_data,
    output din_ready,
    output busy,
    output done,
    output match_pulse,
    output match_cnt,
    output overflow
  );

endinterface

// File: rtl/seqscan_ctrl_seq_match.sv
// seq_match: programmable overlapping Mealy matcher.
// History persists across bytes until clr.
module seq_match
  import seqscan_ctrl_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam int VW = $clog2(PAT_W);

  logic [PAT_W-2:0] r_hist;
  logic [VW-1:0]    r_nvld;
  logic             w_full;
  logic [PAT_W-1:0] w_win;

  // w_full: PAT_W-1 earlier bits seen, so this bit completes a window
  assign w_full = (r_nvld == VW'(PAT_W-1));
  assign w_win  = {r_hist, bit_in};
  assign hit    = en & w_full & (w_win == pattern);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_nvld <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_nvld <= '0;
    end else if (en) begin
      r_hist <= w_win[PAT_W-2:0];
      if (!w_full)
        r_nvld <= r_nvld + VW'(1);
    end
  end

endmodule

// File: rtl/seqscan_ctrl.sv
// seqscan_ctrl: byte-stream pattern scanner with
// saturating match counter and sticky overflow.
module seqscan_ctrl
  import seqscan_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  seqscan_ctrl_if.slave bus
);

  localparam int BI_W = $clog2(DATA_W);

  state_t              r_state;
  state_t              w_next;
  logic [PAT_W-1:0]    r_pat;
  logic [NBYTES_W-1:0] r_nbytes;
  logic [DATA_W-1:0]   r_byte;
  logic [BI_W-1:0]     r_bidx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;
  logic                r_mpulse;
  logic                w_start;
  logic                w_accept;
  logic                w_shift;
  logic                w_bit;
  logic                w_hit;

  assign w_bit = r_byte[r_bidx];

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_accept = 1'b0;
    w_shift  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_start = 1'b1;
          w_next  = (bus.cfg_nbytes == '0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (bus.din_valid) begin
          w_accept = 1'b1;
          w_next   = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_bidx == '0)
          w_next = (r_nbytes == NBYTES_W'(1)) ? DONE : WAIT;
      end
      DONE: w_next = IDLE;
    endcase
    // abort squashes every side effect of this cycle
    if (bus.abort) begin
      w_next   = IDLE;
      w_start  = 1'b0;
      w_accept = 1'b0;
      w_shift  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  seq_match #(
    .PAT_W (PAT_W)
  ) u_match (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_start),
    .en      (w_shift),
    .bit_in  (w_bit),
    .pattern (r_pat),
    .hit     (w_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat    <= '0;
      r_nbytes <= '0;
      r_byte   <= '0;
      r_bidx   <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_mpulse <= 1'b0;
    end else begin
      r_mpulse <= w_hit;
      if (w_start) begin
        r_pat    <= bus.cfg_pattern;
        r_nbytes <= bus.cfg_nbytes;
        r_cnt    <= '0;
        r_ovf    <= 1'b0;
      end
      if (w_accept) begin
        r_byte <= bus.din_data;
        r_bidx <= BI_W'(DATA_W-1);
      end
      if (w_shift) begin
        r_bidx <= r_bidx - BI_W'(1);
        if (r_bidx == '0)
          r_nbytes <= r_nbytes - NBYTES_W'(1);
      end
      if (w_hit) begin
        if (&r_cnt)
          r_ovf <= 1'b1;
        else
          r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.din_ready   = (r_state == WAIT);
  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = (r_state == DONE);
  assign bus.match_pulse = r_mpulse;
  assign bus.match_cnt   = r_cnt;
  assign bus.overflow    = r_ovf;

endmodule
